// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: request/response channels and ALU drive bus of alu_share_ctrl.
interface alu_share_ctrl_if;
   logic        req0Valid, req1Valid, req0Ready, req1Ready;
   logic [31:0] req0A, req0B, req1A, req1B;
   logic [3:0]  req0Op, req1Op;
   logic        rsp0Valid, rsp1Valid, rsp0Ready, rsp1Ready;
   logic [31:0] rspResult;
   logic        rspZero, rspOverflow, rspError;
   logic [31:0] aluInA, aluInB;
   logic [3:0]  aluControl;
   logic [31:0] aluResult;
   logic        aluZero, aluOverflow;
   logic        busy;
   modport master (
      output req0Valid, req1Valid, req0A, req0B, req1A, req1B, req0Op, req1Op,
      output rsp0Ready, rsp1Ready, aluResult, aluZero, aluOverflow,
      input  req0Ready, req1Ready, rsp0Valid, rsp1Valid, rspResult, rspZero,
      input  rspOverflow, rspError, aluInA, aluInB, aluControl, busy
   );
   modport slave (
      input  req0Valid, req1Valid, req0A, req0B, req1A, req1B, req0Op, req1Op,
      input  rsp0Ready, rsp1Ready, aluResult, aluZero, aluOverflow,
      output req0Ready, req1Ready, rsp0Valid, rsp1Valid, rspResult, rspZero,
      output rspOverflow, rspError, aluInA, aluInB, aluControl, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU between two requesters,
// with a settle counter and a registered, back-pressurable response.
module alu_share_ctrl #(
   parameter int EXEC_CYCLES = 1
) (
   input logic clk,
   input logic reset,
   alu_share_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);
   state_t      r_state;
   logic        r_last, r_gnt, r_busy, r_rsp0_valid, r_rsp1_valid, r_zero, r_ovf, r_err;
   logic [3:0]  r_cnt, r_alu_ctl;
   logic [31:0] r_alu_a, r_alu_b, r_result;
   logic        w_idle, w_pick1, w_accept, w_legal, w_rsp_ready;
   assign w_idle      = r_state == IDLE;
   assign w_pick1     = bus.req1Valid & (~bus.req0Valid | ~r_last);
   assign w_accept    = w_idle & (bus.req0Valid | bus.req1Valid);
   assign w_legal     = r_alu_ctl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                          4'b1000, 4'b1001, 4'b1100, 4'b1101};
   assign w_rsp_ready = r_gnt ? bus.rsp1Ready : bus.rsp0Ready;
   assign bus.req0Ready   = w_idle & bus.req0Valid & ~w_pick1;
   assign bus.req1Ready   = w_idle & w_pick1;
   assign bus.rsp0Valid   = r_rsp0_valid;
   assign bus.rsp1Valid   = r_rsp1_valid;
   assign bus.rspResult   = r_result;
   assign bus.rspZero     = r_zero;
   assign bus.rspOverflow = r_ovf;
   assign bus.rspError    = r_err;
   assign bus.aluInA      = r_alu_a;
   assign bus.aluInB      = r_alu_b;
   assign bus.aluControl  = r_alu_ctl;
   assign bus.busy        = r_busy;
   // The ALU drive registers double as the operand latch; 1111 parks the ALU at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last       <= 1'b1;
         r_gnt        <= 1'b0;
         r_cnt        <= 4'd0;
         r_busy       <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_result     <= '0;
         r_zero       <= 1'b0;
         r_ovf        <= 1'b0;
         r_err        <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_ctl    <= 4'hF;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_state   <= EXEC;
               r_gnt     <= w_pick1;
               r_cnt     <= CNT_LOAD;
               r_busy    <= 1'b1;
               r_alu_a   <= w_pick1 ? bus.req1A : bus.req0A;
               r_alu_b   <= w_pick1 ? bus.req1B : bus.req0B;
               r_alu_ctl <= w_pick1 ? bus.req1Op : bus.req0Op;
            end
            EXEC: if (r_cnt == 4'd0) begin
               r_state      <= RESP;
               r_result     <= w_legal ? bus.aluResult : '0;
               r_zero       <= w_legal & bus.aluZero;
               r_ovf        <= (r_alu_ctl == 4'b0010) & bus.aluOverflow;
               r_err        <= ~w_legal;
               r_rsp0_valid <= ~r_gnt;
               r_rsp1_valid <= r_gnt;
               r_alu_a      <= '0;
               r_alu_b      <= '0;
               r_alu_ctl    <= 4'hF;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            RESP: if (w_rsp_ready) begin
               r_state      <= IDLE;
               r_last       <= r_gnt;
               r_busy       <= 1'b0;
               r_rsp0_valid <= 1'b0;
               r_rsp1_valid <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of alu_share_ctrl with EXEC_CYCLES of 1, 3 and 4,
// each instance driving a behavioural ALU.
module tb_alu_share_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   alu_share_ctrl_if b1();
   alu_share_ctrl_if b3();
   alu_share_ctrl_if b4();
   alu_share_ctrl #(.EXEC_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
   alu_share_ctrl #(.EXEC_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
   alu_share_ctrl #(.EXEC_CYCLES(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
   always #5 clk = ~clk;

   // Raw adder carry is reported for every op so the controller's masking is visible;
   // illegal codes other than 1111 return junk with Zero set.
   function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      logic [32:0] s;
      logic [31:0] r;
      logic        z;
      s = {1'b0, a} + {1'b0, b};
      r = '0;
      z = 1'b1;
      case (op)
         4'b0000: begin r = a & b;    z = r == 0; end
         4'b0001: begin r = a | b;    z = r == 0; end
         4'b0010: begin r = s[31:0];  z = r == 0; end
         4'b0110: begin r = a - b;    z = r == 0; end
         4'b1000: begin r = a - b;    z = a == b; end
         4'b1001: begin r = a - b;    z = a != b; end
         4'b1100: begin r = ~(a | b); z = r == 0; end
         4'b1101: begin r = a ^ b;    z = r == 0; end
         4'b1111: begin r = '0;       z = 1'b1;   end
         default: begin r = 32'hDEAD_BEEF; z = 1'b1; end
      endcase
      return {s[32], z, r};
   endfunction

   assign {b1.aluOverflow, b1.aluZero, b1.aluResult} = alu_model(b1.aluInA, b1.aluInB, b1.aluControl);
   assign {b3.aluOverflow, b3.aluZero, b3.aluResult} = alu_model(b3.aluInA, b3.aluInB, b3.aluControl);
   assign {b4.aluOverflow, b4.aluZero, b4.aluResult} = alu_model(b4.aluInA, b4.aluInB, b4.aluControl);

   task automatic send1(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int n;
      n = 0;
      @(negedge clk);
      if (id) begin b1.req1A = a; b1.req1B = b; b1.req1Op = op; b1.req1Valid = 1'b1; end
      else    begin b1.req0A = a; b1.req0B = b; b1.req0Op = op; b1.req0Valid = 1'b1; end
      #1;
      while (!(id ? b1.req1Ready : b1.req0Ready) && n < 20) begin @(negedge clk); #1; n++; end
      if (n == 20) begin checks++; errors++; $display("FAIL send_timeout id=%0d no ready within 20 cycles", id); end
      @(negedge clk);
      if (id) b1.req1Valid = 1'b0; else b1.req0Valid = 1'b0;
   endtask

   task automatic wait_rsp1(input bit id);
      int n;
      n = 0;
      while (!(id ? b1.rsp1Valid : b1.rsp0Valid) && n < 20) begin @(negedge clk); n++; end
      if (n == 20) begin checks++; errors++; $display("FAIL rsp_timeout id=%0d no response within 20 cycles", id); end
   endtask

   task automatic consume1(input bit id);
      if (id) b1.rsp1Ready = 1'b1; else b1.rsp0Ready = 1'b1;
      @(negedge clk);
      b1.rsp1Ready = 1'b0;
      b1.rsp0Ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b1.busy); end
      checks++; if ({b1.rsp0Valid, b1.rsp1Valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", {b1.rsp0Valid, b1.rsp1Valid}); end
      checks++; if ({b1.rspResult, b1.rspZero, b1.rspOverflow, b1.rspError} !== 35'd0) begin errors++; $display("FAIL reset_rsp_data got %h/%b%b%b want 0", b1.rspResult, b1.rspZero, b1.rspOverflow, b1.rspError); end
      checks++; if ({b1.req0Ready, b1.req1Ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {b1.req0Ready, b1.req1Ready}); end
      checks++; if (b1.aluControl !== 4'hF || b1.aluInA !== 32'd0 || b1.aluInB !== 32'd0) begin errors++; $display("FAIL reset_alu_drive got ctl=%h a=%h b=%h want F/0/0", b1.aluControl, b1.aluInA, b1.aluInB); end
      checks++; if (b3.busy !== 1'b0 || b4.aluControl !== 4'hF) begin errors++; $display("FAIL reset_other got busy3=%b ctl4=%h want 0/F", b3.busy, b4.aluControl); end
      reset = 1'b0;
   endtask

   task automatic test_single_add;
      @(negedge clk);
      b1.req0A = 32'd5; b1.req0B = 32'd7; b1.req0Op = 4'b0010; b1.req0Valid = 1'b1;
      #1;
      checks++; if (b1.req0Ready !== 1'b1 || b1.req1Ready !== 1'b0) begin errors++; $display("FAIL add_ready got %b%b want 10", b1.req0Ready, b1.req1Ready); end
      @(negedge clk);
      b1.req0Valid = 1'b0;
      checks++; if (b1.busy !== 1'b1 || b1.aluInA !== 32'd5 || b1.aluInB !== 32'd7 || b1.aluControl !== 4'b0010) begin errors++; $display("FAIL add_exec_drive got busy=%b a=%h b=%h ctl=%h want 1/5/7/2", b1.busy, b1.aluInA, b1.aluInB, b1.aluControl); end
      checks++; if (b1.rsp0Valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp got %b want 0", b1.rsp0Valid); end
      @(negedge clk);
      checks++; if (b1.rsp0Valid !== 1'b1 || b1.rsp1Valid !== 1'b0) begin errors++; $display("FAIL add_rsp_valid got %b%b want 10", b1.rsp0Valid, b1.rsp1Valid); end
      checks++; if (b1.rspResult !== 32'd12) begin errors++; $display("FAIL add_result got %h want 0000000c", b1.rspResult); end
      checks++; if ({b1.rspZero, b1.rspOverflow, b1.rspError} !== 3'b000) begin errors++; $display("FAIL add_flags got %b want 000", {b1.rspZero, b1.rspOverflow, b1.rspError}); end
      checks++; if (b1.aluControl !== 4'hF) begin errors++; $display("FAIL add_resp_alu_idle got %h want f", b1.aluControl); end
      consume1(1'b0);
      checks++; if (b1.busy !== 1'b0 || b1.rsp0Valid !== 1'b0) begin errors++; $display("FAIL add_back_idle got busy=%b v0=%b want 0/0", b1.busy, b1.rsp0Valid); end
   endtask

   task automatic test_tie;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      b1.req0A = 32'd10; b1.req0B = 32'd3; b1.req0Op = 4'b0110; b1.req0Valid = 1'b1;
      b1.req1A = 32'hF0F0_0000; b1.req1B = 32'h0F0F_0000; b1.req1Op = 4'b1101; b1.req1Valid = 1'b1;
      #1;
      checks++; if ({b1.req0Ready, b1.req1Ready} !== 2'b10) begin errors++; $display("FAIL tie1_grant got %b want 10", {b1.req0Ready, b1.req1Ready}); end
      @(negedge clk);
      b1.req0Valid = 1'b0;
      @(negedge clk);
      checks++; if (b1.rsp0Valid !== 1'b1 || b1.rsp1Valid !== 1'b0 || b1.rspResult !== 32'd7) begin errors++; $display("FAIL tie1_rsp got v=%b%b r=%h want 10/7", b1.rsp0Valid, b1.rsp1Valid, b1.rspResult); end
      checks++; if (b1.req1Ready !== 1'b0) begin errors++; $display("FAIL tie_resp_ignores_req got %b want 0", b1.req1Ready); end
      consume1(1'b0);
      b1.req0A = 32'd3; b1.req0B = 32'd4; b1.req0Op = 4'b0001; b1.req0Valid = 1'b1;
      #1;
      checks++; if ({b1.req0Ready, b1.req1Ready} !== 2'b01) begin errors++; $display("FAIL tie2_grant got %b want 01", {b1.req0Ready, b1.req1Ready}); end
      @(negedge clk);
      b1.req1Valid = 1'b0;
      @(negedge clk);
      checks++; if (b1.rsp1Valid !== 1'b1 || b1.rsp0Valid !== 1'b0 || b1.rspResult !== 32'hFFFF_0000) begin errors++; $display("FAIL tie2_rsp got v=%b%b r=%h want 01/ffff0000", b1.rsp0Valid, b1.rsp1Valid, b1.rspResult); end
      consume1(1'b1);
      b1.req1A = 32'd1; b1.req1B = 32'd1; b1.req1Op = 4'b0000; b1.req1Valid = 1'b1;
      #1;
      checks++; if ({b1.req0Ready, b1.req1Ready} !== 2'b10) begin errors++; $display("FAIL tie3_grant got %b want 10", {b1.req0Ready, b1.req1Ready}); end
      b1.req1Valid = 1'b0;
      @(negedge clk);
      b1.req0Valid = 1'b0;
      wait_rsp1(1'b0);
      checks++; if (b1.rsp0Valid !== 1'b1 || b1.rspResult !== 32'd7) begin errors++; $display("FAIL tie3_rsp got v=%b r=%h want 1/7", b1.rsp0Valid, b1.rspResult); end
      consume1(1'b0);
   endtask

   task automatic test_overflow;
      send1(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
      wait_rsp1(1'b1);
      checks++; if (b1.rspResult !== 32'd0 || b1.rspOverflow !== 1'b1 || b1.rspZero !== 1'b1) begin errors++; $display("FAIL ovf_add got r=%h o=%b z=%b want 0/1/1", b1.rspResult, b1.rspOverflow, b1.rspZero); end
      consume1(1'b1);
      send1(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000);
      wait_rsp1(1'b0);
      checks++; if (b1.rspResult !== 32'hFFFF_FFFF || b1.rspOverflow !== 1'b0) begin errors++; $display("FAIL ovf_and_masked got r=%h o=%b want ffffffff/0", b1.rspResult, b1.rspOverflow); end
      consume1(1'b0);
   endtask

   task automatic test_branch;
      send1(1'b0, 32'd9, 32'd9, 4'b1000);
      wait_rsp1(1'b0);
      checks++; if (b1.rspZero !== 1'b1 || b1.rspResult !== 32'd0 || b1.rspError !== 1'b0) begin errors++; $display("FAIL beq_equal got z=%b r=%h e=%b want 1/0/0", b1.rspZero, b1.rspResult, b1.rspError); end
      consume1(1'b0);
      send1(1'b1, 32'd9, 32'd9, 4'b1001);
      wait_rsp1(1'b1);
      checks++; if (b1.rspZero !== 1'b0) begin errors++; $display("FAIL bne_equal got z=%b want 0", b1.rspZero); end
      consume1(1'b1);
      send1(1'b0, 32'd9, 32'd8, 4'b1001);
      wait_rsp1(1'b0);
      checks++; if (b1.rspZero !== 1'b1 || b1.rspResult !== 32'd1) begin errors++; $display("FAIL bne_differ got z=%b r=%h want 1/1", b1.rspZero, b1.rspResult); end
      consume1(1'b0);
   endtask

   task automatic test_back_to_back;
      logic [8:0] rdy, vld;
      rdy = '0;
      vld = '0;
      @(negedge clk);
      b1.req0A = 32'd1; b1.req0B = 32'd2; b1.req0Op = 4'b0010; b1.req0Valid = 1'b1; b1.rsp0Ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         #1;
         rdy[i] = b1.req0Ready;
         vld[i] = b1.rsp0Valid;
         @(negedge clk);
      end
      b1.req0Valid = 1'b0;
      b1.rsp0Ready = 1'b0;
      checks++; if (rdy !== 9'b001_001_001) begin errors++; $display("FAIL b2b_accept_pattern got %b want 001001001", rdy); end
      checks++; if (vld !== 9'b100_100_100) begin errors++; $display("FAIL b2b_rsp_pattern got %b want 100100100", vld); end
      checks++; if (b1.rspResult !== 32'd3) begin errors++; $display("FAIL b2b_result got %h want 3", b1.rspResult); end
   endtask

   task automatic test_illegal_multicycle;
      int exec_n, busy_n;
      exec_n = 0;
      busy_n = 0;
      @(negedge clk);
      b3.req0A = 32'd5; b3.req0B = 32'd6; b3.req0Op = 4'b0011; b3.req0Valid = 1'b1;
      #1;
      checks++; if (b3.req0Ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %b want 1", b3.req0Ready); end
      @(negedge clk);
      b3.req0Valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (b3.aluControl === 4'b0011) exec_n++;
         if (b3.busy === 1'b1 && b3.rsp0Valid === 1'b0) busy_n++;
         @(negedge clk);
      end
      checks++; if (exec_n != 3 || busy_n != 3) begin errors++; $display("FAIL ill_exec_cycles got drive=%0d busy=%0d want 3/3", exec_n, busy_n); end
      checks++; if (b3.rsp0Valid !== 1'b1 || b3.aluControl !== 4'hF) begin errors++; $display("FAIL ill_rsp_valid got v=%b ctl=%h want 1/f", b3.rsp0Valid, b3.aluControl); end
      checks++; if ({b3.rspError, b3.rspZero, b3.rspOverflow} !== 3'b100 || b3.rspResult !== 32'd0) begin errors++; $display("FAIL ill_capture got e/z/o=%b r=%h want 100/0", {b3.rspError, b3.rspZero, b3.rspOverflow}, b3.rspResult); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (b3.rsp0Valid !== 1'b1 || b3.busy !== 1'b1 || b3.rspResult !== 32'd0 || {b3.rspError, b3.rspZero, b3.rspOverflow} !== 3'b100) begin
            errors++; $display("FAIL ill_hold_%0d got v=%b busy=%b r=%h e/z/o=%b want 1/1/0/100", i, b3.rsp0Valid, b3.busy, b3.rspResult, {b3.rspError, b3.rspZero, b3.rspOverflow});
         end
      end
      b3.rsp0Ready = 1'b1;
      @(negedge clk);
      b3.rsp0Ready = 1'b0;
      checks++; if (b3.busy !== 1'b0 || b3.rsp0Valid !== 1'b0) begin errors++; $display("FAIL ill_release got busy=%b v=%b want 0/0", b3.busy, b3.rsp0Valid); end
   endtask

   task automatic test_reset_mid_exec;
      int n;
      n = 0;
      @(negedge clk);
      b4.req0A = 32'd2; b4.req0B = 32'd2; b4.req0Op = 4'b0010; b4.req0Valid = 1'b1;
      @(negedge clk);
      b4.req0Valid = 1'b0;
      @(negedge clk);
      checks++; if (b4.busy !== 1'b1 || b4.aluControl !== 4'b0010) begin errors++; $display("FAIL mid_in_exec got busy=%b ctl=%h want 1/2", b4.busy, b4.aluControl); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (b4.busy !== 1'b0 || {b4.rsp0Valid, b4.rsp1Valid} !== 2'b00) begin errors++; $display("FAIL mid_reset_state got busy=%b v=%b want 0/00", b4.busy, {b4.rsp0Valid, b4.rsp1Valid}); end
      checks++; if (b4.aluControl !== 4'hF || b4.aluInA !== 32'd0) begin errors++; $display("FAIL mid_reset_alu got ctl=%h a=%h want f/0", b4.aluControl, b4.aluInA); end
      repeat (6) @(negedge clk);
      checks++; if (b4.rsp0Valid !== 1'b0 || b4.busy !== 1'b0) begin errors++; $display("FAIL mid_dropped got v=%b busy=%b want 0/0", b4.rsp0Valid, b4.busy); end
      b4.req1A = 32'h0000_00FF; b4.req1B = 32'h0000_000F; b4.req1Op = 4'b1101; b4.req1Valid = 1'b1;
      #1;
      checks++; if (b4.req1Ready !== 1'b1) begin errors++; $display("FAIL mid_fresh_ready got %b want 1", b4.req1Ready); end
      @(negedge clk);
      b4.req1Valid = 1'b0;
      while (b4.rsp1Valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (n != 4) begin errors++; $display("FAIL mid_fresh_latency got %0d want 4", n); end
      checks++; if (b4.rspResult !== 32'h0000_00F0 || b4.rsp0Valid !== 1'b0) begin errors++; $display("FAIL mid_fresh_rsp got r=%h v0=%b want f0/0", b4.rspResult, b4.rsp0Valid); end
      b4.rsp1Ready = 1'b1;
      @(negedge clk);
      b4.rsp1Ready = 1'b0;
   endtask

   initial begin
      {b1.req0Valid, b1.req1Valid, b1.rsp0Ready, b1.rsp1Ready} = '0;
      {b1.req0A, b1.req0B, b1.req1A, b1.req1B, b1.req0Op, b1.req1Op} = '0;
      {b3.req0Valid, b3.req1Valid, b3.rsp0Ready, b3.rsp1Ready} = '0;
      {b3.req0A, b3.req0B, b3.req1A, b3.req1B, b3.req0Op, b3.req1Op} = '0;
      {b4.req0Valid, b4.req1Valid, b4.rsp0Ready, b4.rsp1Ready} = '0;
      {b4.req0A, b4.req0B, b4.req1A, b4.req1B, b4.req0Op, b4.req1Op} = '0;
      test_reset;
      test_single_add;
      test_tie;
      test_overflow;
      test_branch;
      test_back_to_back;
      test_illegal_multicycle;
      test_reset_mid_exec;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single 32-bit `alu` datapath between two requesters (e.g. the main execute path and a branch/address helper). It accepts one operation at a time through valid/ready handshakes, arbitrates round-robin, and drives the ALU operands and opcode for a configurable number of settle cycles. It then captures result and flags into a registered response held for the winning requester. It sits directly in front of the `alu` instance; the ALU remains purely combinational.

## Interface
- `EXEC_CYCLES`, default 1: cycles the ALU inputs are held before capture (1..15).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0Valid` / `req1Valid` in 1: request pending.
- `req0Ready` / `req1Ready` out 1: request accepted this cycle.
- `req0A`, `req0B` / `req1A`, `req1B` in 32: operands.
- `req0Op` / `req1Op` in 4: ALU opcode.
- `rsp0Valid` / `rsp1Valid` out 1: response available.
- `rsp0Ready` / `rsp1Ready` in 1: response consumed.
- `rspResult` out 32: captured ALU result, shared by both response channels.
- `rspZero`, `rspOverflow`, `rspError` out 1: captured flags.
- `aluInA`, `aluInB` out 32: to ALU.
- `aluControl` out 4: to ALU.
- `aluResult` in 32, `aluZero` in 1, `aluOverflow` in 1: from ALU.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If exactly one `reqNValid` is high, that requester wins.
  - If both are high, the requester not equal to `lastGrant` wins.
  - `reqNReady` is asserted combinationally only to the winner, only in IDLE.
  - On the accept edge: latch A, B, Op and grant id; load counter with `EXEC_CYCLES-1`; go to EXEC.
- **EXEC**
  - `aluInA`/`aluInB`/`aluControl` = latched values.
  - Counter decrements each cycle.
  - At counter==0: capture `aluResult`, `aluZero` and the masked overflow into the response registers; go to RESP.
- **Outside EXEC**: `aluInA`=`aluInB`=0 and `aluControl`=4'b1111. This is an unmapped opcode, so the ALU outputs 0.
- **Legal opcodes**: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 BEQ, 1001 BNE, 1100 NOR, 1101 XOR.
  - An illegal opcode still runs EXEC for the full count.
  - The capture is then `rspResult`=0, `rspZero`=0, `rspOverflow`=0, `rspError`=1.
- **Overflow masking**: `rspOverflow` = `aluOverflow` only when Op==0010; otherwise 0.
- **RESP**
  - `rspNValid` = 1 for the granted id only; the response registers are held stable.
  - When `rspNReady` is high: set `lastGrant` = granted id, go to IDLE.
  - No new request is accepted in that same cycle.
- **Request inputs**: ignored outside IDLE. A requester keeps its valid high until it sees its ready.

## Timing
- **Reset** (synchronous, on the clock edge with `reset`=1):
  - state=IDLE, `lastGrant`=1 (so req0 wins the first tie), counter=0.
  - All `rsp*` outputs 0, `busy`=0, `req*Ready`=0.
  - ALU drive at idle values.
- **Latency**: request accepted at edge T.
  - EXEC occupies cycles T+1 .. T+EXEC_CYCLES.
  - `rspNValid` is first high in cycle T+EXEC_CYCLES+1.
- **Throughput**: with `rspNReady` held high, one operation per EXEC_CYCLES+2 cycles, because of the IDLE bubble.
- **Reset during EXEC or RESP**: the transaction is dropped and no response is produced. `reset` has priority over every other input.
- **Back-pressure**: RESP may last indefinitely; `rspResult` and flags must not change while waiting.
- **Simultaneous events**:
  - `reqNValid` high during RESP has no effect.
  - Response consume and a new request in the same cycle: the new request is accepted on the following IDLE cycle.
- **Counter**: 4 bits, no wrap. The EXEC_CYCLES=1 case exits EXEC after exactly one cycle.

## Test plan
- **Single ADD**: req0 A=5, B=7, Op=0010, EXEC_CYCLES=1.
  - `req0Ready` is high in the accept cycle.
  - 2 cycles later `rsp0Valid`=1, `rspResult`=12, Zero=0, Overflow=0, Error=0.
  - `rsp1Valid` stays 0.
- **Tie after reset**: both requesters valid (req0 SUB 10-3, req1 XOR F0F0_0000^0F0F_0000).
  - req0 served first with result 7.
  - Then req1 with result FFFF_0000.
  - A second tie is won by req0 again only after req1 has been served.
- **Add overflow masking**:
  - req1 ADD FFFF_FFFF+1 gives `rspResult`=0, `rspOverflow`=1.
  - AND FFFF_FFFF&FFFF_FFFF gives `rspOverflow`=0.
- **Branch compare**:
  - BEQ 9,9 gives Zero=1, Result=0.
  - BNE 9,9 gives Zero=0.
- **Illegal op with multi-cycle settle**: Op=0011, EXEC_CYCLES=3.
  - `busy` is high for 3 EXEC cycles.
  - Response: Error=1, Result=0, Zero=0.
  - Hold `rsp0Ready`=0 for 5 cycles: outputs stay stable.
- **Reset mid-EXEC**: with EXEC_CYCLES=4, assert `reset` in the 2nd EXEC cycle.
  - Next cycle: `busy`=0 and no `rsp*Valid`.
  - `aluControl`=1111.
  - A fresh request is then served normally.
